// File: rtl/free_list_ctl.sv
// free_list_ctl: physical-register free list for rename, with a ring of
// head-pointer checkpoints for single-cycle mispredict recovery.
module free_list_ctl #(
   parameter  int PHYS_REG_NUM  = 64,
   parameter  int ARCH_REG_NUM  = 32,
   parameter  int RECLAIM_WIDTH = 4,
   parameter  int CHECKPOINTS   = 4,
   localparam int PIDX          = $clog2(PHYS_REG_NUM),
   localparam int CIDX          = $clog2(CHECKPOINTS)
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          alloc_req,
   output logic                          alloc_grant,
   output logic [PIDX-1:0]               alloc_preg,
   input  logic [RECLAIM_WIDTH-1:0]      reclaim_valid,
   input  logic [RECLAIM_WIDTH*PIDX-1:0] reclaim_preg,
   input  logic                          ckpt_save,
   output logic [CIDX-1:0]               ckpt_id,
   output logic                          ckpt_full,
   input  logic                          ckpt_release,
   input  logic                          restore_valid,
   input  logic [CIDX-1:0]               restore_id,
   output logic [PIDX:0]                 free_count,
   output logic                          empty,
   output logic                          ckpt_overflow
);

   localparam logic [PIDX:0]   FREE_RST = (PIDX+1)'(PHYS_REG_NUM - ARCH_REG_NUM);
   localparam logic [PIDX-1:0] HEAD_RST = PIDX'(ARCH_REG_NUM % PHYS_REG_NUM);
   localparam logic [CIDX:0]   CKPT_MAX = (CIDX+1)'(CHECKPOINTS);

   logic [PIDX-1:0] list_q [PHYS_REG_NUM];
   logic [PIDX-1:0] slot_q [CHECKPOINTS];
   logic [PIDX-1:0] head_q;
   logic [PIDX-1:0] tail_q;
   logic [PIDX:0]   free_q;
   logic [CIDX-1:0] ckpt_head_q;
   logic [CIDX:0]   ckpt_cnt_q;
   logic            ovf_q;

   logic [PIDX-1:0] lane_addr [RECLAIM_WIDTH];
   logic [PIDX:0]   pop;
   logic [PIDX-1:0] head_alloc;
   logic [PIDX-1:0] head_nx;
   logic [PIDX-1:0] tail_nx;
   logic [PIDX:0]   free_nx;
   logic [CIDX-1:0] ckpt_head_rel;
   logic [CIDX:0]   ckpt_cnt_rel;
   logic [CIDX:0]   ckpt_cnt_nx;
   logic            rel;
   logic            save_ok;
   logic            save_full;

   // Compact valid lanes onto consecutive slots starting at tail.
   always_comb begin
      pop = '0;
      for (int i = 0; i < RECLAIM_WIDTH; i++) begin
         lane_addr[i] = tail_q + pop[PIDX-1:0];
         pop = pop + (PIDX+1)'(reclaim_valid[i]);
      end
   end

   assign empty         = (free_q == '0);
   assign alloc_grant   = rst_n & alloc_req & ~empty & ~restore_valid;
   assign alloc_preg    = list_q[head_q];
   assign free_count    = free_q;
   assign ckpt_id       = ckpt_head_q + ckpt_cnt_q[CIDX-1:0];
   assign ckpt_full     = (ckpt_cnt_q == CKPT_MAX);
   assign ckpt_overflow = ovf_q;

   always_comb begin
      head_alloc    = head_q + PIDX'(alloc_grant);
      tail_nx       = tail_q + pop[PIDX-1:0];
      rel           = ckpt_release & (ckpt_cnt_q != '0);
      save_ok       = ckpt_save & ~restore_valid & ~ckpt_full;
      save_full     = ckpt_save & ~restore_valid & ckpt_full;
      ckpt_head_rel = ckpt_head_q + CIDX'(rel);
      ckpt_cnt_rel  = ckpt_cnt_q - (CIDX+1)'(rel);
      head_nx       = head_alloc;
      free_nx       = free_q - (PIDX+1)'(alloc_grant) + pop;
      ckpt_cnt_nx   = ckpt_cnt_rel + (CIDX+1)'(save_ok);
      if (restore_valid) begin
         head_nx = slot_q[restore_id];
         free_nx = {1'b0, tail_nx - head_nx};
         // Restoring the slot being released empties the ring.
         if (rel && (restore_id == ckpt_head_q))
            ckpt_cnt_nx = '0;
         else
            ckpt_cnt_nx = {1'b0, restore_id - ckpt_head_rel};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < PHYS_REG_NUM; i++)
            list_q[i] <= PIDX'(i);
         for (int c = 0; c < CHECKPOINTS; c++)
            slot_q[c] <= '0;
         head_q      <= HEAD_RST;
         tail_q      <= '0;
         free_q      <= FREE_RST;
         ckpt_head_q <= '0;
         ckpt_cnt_q  <= '0;
         ovf_q       <= 1'b0;
      end else begin
         for (int i = 0; i < RECLAIM_WIDTH; i++)
            if (reclaim_valid[i])
               list_q[lane_addr[i]] <= reclaim_preg[i*PIDX +: PIDX];
         if (save_ok)
            slot_q[ckpt_id] <= head_alloc;
         head_q      <= head_nx;
         tail_q      <= tail_nx;
         free_q      <= free_nx;
         ckpt_head_q <= ckpt_head_rel;
         ckpt_cnt_q  <= ckpt_cnt_nx;
         if (save_full)
            ovf_q <= 1'b1;
      end
   end

   a_free_bound: assert property (@(posedge clk) disable iff (!rst_n)
      free_q <= FREE_RST);

   a_restore_win: assert property (@(posedge clk) disable iff (!rst_n)
      restore_valid |-> ({1'b0, CIDX'(restore_id - ckpt_head_q)} < ckpt_cnt_q));

endmodule

// File: tb/tb_free_list_ctl.sv
// tb_free_list_ctl: vector table, directed corner sequences and a
// queue-based reference model under random stimulus.
module tb_free_list_ctl;

   logic        clk;
   logic        rst_n;
   logic        alloc_req;
   logic        alloc_grant;
   logic [5:0]  alloc_preg;
   logic [3:0]  reclaim_valid;
   logic [23:0] reclaim_preg;
   logic        ckpt_save;
   logic [1:0]  ckpt_id;
   logic        ckpt_full;
   logic        ckpt_release;
   logic        restore_valid;
   logic [1:0]  restore_id;
   logic [6:0]  free_count;
   logic        empty;
   logic        ckpt_overflow;

   int total;
   int bad;

   free_list_ctl dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .alloc_req     (alloc_req),
      .alloc_grant   (alloc_grant),
      .alloc_preg    (alloc_preg),
      .reclaim_valid (reclaim_valid),
      .reclaim_preg  (reclaim_preg),
      .ckpt_save     (ckpt_save),
      .ckpt_id       (ckpt_id),
      .ckpt_full     (ckpt_full),
      .ckpt_release  (ckpt_release),
      .restore_valid (restore_valid),
      .restore_id    (restore_id),
      .free_count    (free_count),
      .empty         (empty),
      .ckpt_overflow (ckpt_overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       req;
      logic       sv;
      logic       rl;
      logic       rv;
      logic [1:0] rid;
      logic       g;
      logic [5:0] p;
      logic [6:0] fc;
      logic       emp;
      logic [1:0] id;
      logic       full;
      logic       ovf;
   } vec_t;

   vec_t tbl [17];

   function automatic vec_t mkv(int req, int sv, int rl, int rv, int rid,
                                int g, int p, int fc, int id, int full,
                                int ovf);
      vec_t v;
      v.req  = 1'(req);
      v.sv   = 1'(sv);
      v.rl   = 1'(rl);
      v.rv   = 1'(rv);
      v.rid  = 2'(rid);
      v.g    = 1'(g);
      v.p    = 6'(p);
      v.fc   = 7'(fc);
      v.emp  = (fc == 0);
      v.id   = 2'(id);
      v.full = 1'(full);
      v.ovf  = 1'(ovf);
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=0x%0h required=0x%0h t=%0t",
                  nm, act, exp, $time);
      end
   endtask

   task automatic idle();
      alloc_req     = 1'b0;
      reclaim_valid = '0;
      reclaim_preg  = '0;
      ckpt_save     = 1'b0;
      ckpt_release  = 1'b0;
      restore_valid = 1'b0;
      restore_id    = '0;
   endtask

   task automatic do_reset();
      idle();
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic alloc_cycle(input int exp_p, input string nm);
      @(negedge clk);
      idle();
      alloc_req = 1'b1;
      #1;
      chk(nm, {alloc_grant, alloc_preg}, {1'b1, 6'(exp_p)});
   endtask

   // reference model state
   int fl[$];
   int pool[$];
   int alog[$];
   int ck[$];
   int base;
   bit movf;

   task automatic model_init();
      fl.delete();
      pool.delete();
      alog.delete();
      ck.delete();
      for (int i = 32; i < 64; i++) fl.push_back(i);
      for (int i = 0; i < 32; i++) pool.push_back(i);
      base = 0;
      movf = 0;
   endtask

   task automatic random_cycle();
      int nmax, n, j, k, pre, idx, p;
      int rec[$];
      bit req, sv, rl, rv, g;
      logic [3:0] mask;
      @(negedge clk);
      idle();
      req  = ($urandom_range(0, 9) < 6);
      nmax = pool.size() - 32;
      if (nmax > 4) nmax = 4;
      n = (nmax > 0) ? int'($urandom_range(0, nmax)) : 0;
      mask = '0;
      while ($countones(mask) < n) mask[$urandom_range(0, 3)] = 1'b1;
      reclaim_preg = 24'($urandom);
      for (int l = 0; l < 4; l++) begin
         if (mask[l]) begin
            idx = $urandom_range(0, pool.size() - 1);
            p = pool[idx];
            pool.delete(idx);
            reclaim_preg[l*6 +: 6] = 6'(p);
            rec.push_back(p);
         end
      end
      sv = ($urandom_range(0, 99) < 15);
      rl = ($urandom_range(0, 99) < 25);
      rv = (ck.size() > 0) && ($urandom_range(0, 99) < 8);
      j  = rv ? int'($urandom_range(0, ck.size() - 1)) : 0;
      alloc_req     = req;
      reclaim_valid = mask;
      ckpt_save     = sv;
      ckpt_release  = rl;
      restore_valid = rv;
      restore_id    = 2'((base + j) % 4);
      #1;
      g = req && (fl.size() > 0) && !rv;
      chk("rnd_grant", 32'(alloc_grant), 32'(g));
      chk("rnd_free_count", 32'(free_count), fl.size());
      chk("rnd_empty", 32'(empty), 32'(fl.size() == 0));
      chk("rnd_ckpt_id", 32'(ckpt_id), (base + ck.size()) % 4);
      chk("rnd_ckpt_full", 32'(ckpt_full), 32'(ck.size() == 4));
      chk("rnd_overflow", 32'(ckpt_overflow), 32'(movf));
      if (fl.size() > 0) chk("rnd_preg", 32'(alloc_preg), fl[0]);
      // apply this cycle's effects to the model
      if (g) alog.push_back(fl.pop_front());
      pre = ck.size();
      if (rv) begin
         k = ck[j];
         for (int i = alog.size() - 1; i >= k; i--) fl.push_front(alog[i]);
         while (alog.size() > k) void'(alog.pop_back());
         while (ck.size() > j) void'(ck.pop_back());
         if (rl) begin
            if (ck.size() > 0) void'(ck.pop_front());
            base = (base + 1) % 4;
         end
      end else begin
         if (rl && pre > 0) begin
            void'(ck.pop_front());
            base = (base + 1) % 4;
         end
         if (sv && pre < 4) ck.push_back(alog.size());
         else if (sv) movf = 1;
      end
      foreach (rec[i]) fl.push_back(rec[i]);
      if (ck.size() == 0) begin
         foreach (alog[i]) pool.push_back(alog[i]);
         alog.delete();
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b1;
      idle();

      tbl[0]  = mkv(1, 0, 0, 0, 0, 1, 32, 32, 0, 0, 0);
      tbl[1]  = mkv(1, 0, 0, 0, 0, 1, 33, 31, 0, 0, 0);
      tbl[2]  = mkv(0, 1, 0, 0, 0, 0, 34, 30, 0, 0, 0);
      tbl[3]  = mkv(1, 0, 0, 0, 0, 1, 34, 30, 1, 0, 0);
      tbl[4]  = mkv(1, 0, 0, 0, 0, 1, 35, 29, 1, 0, 0);
      tbl[5]  = mkv(1, 0, 0, 0, 0, 1, 36, 28, 1, 0, 0);
      tbl[6]  = mkv(1, 0, 0, 0, 0, 1, 37, 27, 1, 0, 0);
      tbl[7]  = mkv(1, 0, 0, 0, 0, 1, 38, 26, 1, 0, 0);
      tbl[8]  = mkv(1, 0, 0, 1, 0, 0, 39, 25, 1, 0, 0);
      tbl[9]  = mkv(1, 0, 0, 0, 0, 1, 34, 30, 0, 0, 0);
      tbl[10] = mkv(0, 1, 0, 0, 0, 0, 35, 29, 0, 0, 0);
      tbl[11] = mkv(0, 1, 0, 0, 0, 0, 35, 29, 1, 0, 0);
      tbl[12] = mkv(0, 1, 0, 0, 0, 0, 35, 29, 2, 0, 0);
      tbl[13] = mkv(0, 1, 0, 0, 0, 0, 35, 29, 3, 0, 0);
      tbl[14] = mkv(0, 1, 0, 0, 0, 0, 35, 29, 0, 1, 0);
      tbl[15] = mkv(0, 0, 1, 0, 0, 0, 35, 29, 0, 1, 1);
      tbl[16] = mkv(0, 0, 0, 0, 0, 0, 35, 29, 0, 0, 1);

      // reset state
      do_reset();
      #1;
      chk("reset_state",
          {alloc_grant, alloc_preg, free_count, empty, ckpt_id, ckpt_full,
           ckpt_overflow},
          {1'b0, 6'd32, 7'd32, 1'b0, 2'd0, 1'b0, 1'b0});

      // vector table: alloc, checkpoint, restore, ring fill and wrap
      foreach (tbl[i]) begin
         @(negedge clk);
         idle();
         alloc_req     = tbl[i].req;
         ckpt_save     = tbl[i].sv;
         ckpt_release  = tbl[i].rl;
         restore_valid = tbl[i].rv;
         restore_id    = tbl[i].rid;
         #1;
         chk($sformatf("vec%0d", i),
             {alloc_grant, alloc_preg, free_count, empty, ckpt_id, ckpt_full,
              ckpt_overflow},
             {tbl[i].g, tbl[i].p, tbl[i].fc, tbl[i].emp, tbl[i].id,
              tbl[i].full, tbl[i].ovf});
      end

      // drain, then reclaim with no same-cycle bypass
      do_reset();
      for (int i = 0; i < 32; i++) alloc_cycle(32 + i, "drain");
      @(negedge clk);
      alloc_req = 1'b1;
      #1;
      chk("drained", {empty, alloc_grant, free_count}, {1'b1, 1'b0, 7'd0});
      @(negedge clk);
      alloc_req     = 1'b1;
      reclaim_valid = 4'b1010;
      reclaim_preg  = {6'd9, 6'd62, 6'd5, 6'd63};
      #1;
      chk("no_bypass", {empty, alloc_grant, free_count}, {1'b1, 1'b0, 7'd0});
      @(negedge clk);
      idle();
      alloc_req = 1'b1;
      #1;
      chk("reclaim_a", {alloc_grant, alloc_preg, free_count},
          {1'b1, 6'd5, 7'd2});
      @(negedge clk);
      #1;
      chk("reclaim_b", {alloc_grant, alloc_preg, free_count},
          {1'b1, 6'd9, 7'd1});
      @(negedge clk);
      #1;
      chk("reclaim_empty", {empty, alloc_grant, free_count},
          {1'b1, 1'b0, 7'd0});

      // restore together with alloc request and a 3-lane reclaim
      do_reset();
      for (int i = 0; i < 3; i++) alloc_cycle(32 + i, "pre_save");
      @(negedge clk);
      idle();
      ckpt_save = 1'b1;
      for (int i = 0; i < 2; i++) alloc_cycle(35 + i, "post_save");
      @(negedge clk);
      idle();
      alloc_req     = 1'b1;
      reclaim_valid = 4'b0111;
      reclaim_preg  = {6'd0, 6'd3, 6'd2, 6'd1};
      restore_valid = 1'b1;
      restore_id    = 2'd0;
      #1;
      chk("restore_grant", 32'(alloc_grant), 32'd0);
      @(negedge clk);
      idle();
      #1;
      chk("restore_state", {free_count, alloc_preg, ckpt_id, ckpt_full},
          {7'd32, 6'd35, 2'd0, 1'b0});
      for (int i = 0; i < 29; i++) alloc_cycle(35 + i, "after_restore");
      for (int i = 0; i < 3; i++) alloc_cycle(1 + i, "tail_lane");
      @(negedge clk);
      idle();
      #1;
      chk("tail_drained", {empty, free_count}, {1'b1, 7'd0});

      // asynchronous reset in the middle of an alloc burst
      do_reset();
      for (int i = 0; i < 10; i++) begin
         alloc_cycle(32 + i, "burst");
         if (i == 3 || i == 7) ckpt_save = 1'b1;
      end
      @(negedge clk);
      idle();
      alloc_req = 1'b1;
      #1;
      chk("pre_reset", {ckpt_id, free_count}, {2'd2, 7'd22});
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_reset",
          {alloc_grant, alloc_preg, free_count, ckpt_full, ckpt_overflow,
           ckpt_id},
          {1'b0, 6'd32, 7'd32, 1'b0, 1'b0, 2'd0});
      @(negedge clk);
      idle();
      rst_n = 1'b1;

      // random traffic against the queue model
      do_reset();
      model_init();
      for (int c = 0; c < 3000; c++) random_cycle();

      @(negedge clk);
      idle();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
